// File: rtl/axi_pkg.sv
// Shared AXI definitions for the slave write path (and the future read path).
//   burst_t   : AXI burst encodings FIXED/INCR/WRAP/RSVD
//   RESP_*    : AXI response codes
//   state_t   : write-controller FSM states
//   wrap_len_ok : legal WRAP burst lengths (2, 4, 8 or 16 beats)
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI next-beat address generator.
//   addr      : byte address of the current beat
//   len       : burst length minus 1
//   size      : log2(bytes per beat)
//   burst     : FIXED / INCR / WRAP (RSVD holds the address)
//   next_addr : byte address of the following beat
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [2:0]            size,
  input  burst_t                burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  always_comb begin
    step      = ADDR_WIDTH'(1) << size;
    incr      = addr + step;
    // Wrap window is (len+1) beats of (1<<size) bytes; the low bits inside the
    // window advance, the high bits stay at the window base.
    wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    next_addr = addr;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = incr;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
      default:     next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi_slave_wr_ctrl.sv
// AXI4 slave write-path controller: accepts one AW burst at a time, turns each
// W beat into a single-cycle memory write, and returns one B response.
//   aclk/aresetn             : clock, asynchronous active-low reset
//   aw* (id/addr/len/size/burst/valid/ready) : write address channel
//   w*  (data/strb/last/valid/ready)         : write data channel
//   b*  (id/resp/valid/ready)                : write response channel
//   mem_we/mem_addr/mem_wdata/mem_wstrb      : word-RAM write port
module axi_slave_wr_ctrl
  import axi_pkg::*;
#(
  parameter  int ID_WIDTH   = 4,
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [ID_WIDTH-1:0]   awid,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [7:0]            awlen,
  input  logic [2:0]            awsize,
  input  logic [1:0]            awburst,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0] wstrb,
  input  logic                  wlast,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [ID_WIDTH-1:0]   bid,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [STRB_WIDTH-1:0] mem_wstrb
);

  localparam logic [2:0] SIZE_MAX = 3'($clog2(STRB_WIDTH));

  state_t                state;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  burst_t                burst_q;
  logic [7:0]            beat_cnt;
  logic                  err_early_q;
  logic                  err_late_q;

  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  aw_err;
  logic                  w_hs;
  logic                  last_beat;
  logic                  wlast_bad;

  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .addr      (addr_q),
    .len       (len_q),
    .size      (size_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  always_comb begin
    aw_err    = (awburst == BURST_RSVD) || (awsize > SIZE_MAX) ||
                ((awburst == BURST_WRAP) && !wrap_len_ok(awlen));
    w_hs      = (state == ST_DATA) && wvalid && wready;
    last_beat = (beat_cnt == len_q);
    // The beat counter, not wlast, ends the burst; disagreement is only flagged.
    wlast_bad = (wlast != last_beat);
  end

  // Erroneous bursts still consume their beats but never touch memory.
  assign mem_we    = w_hs && !err_early_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata;
  assign mem_wstrb = wstrb;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= ST_IDLE;
      awready     <= 1'b0;
      wready      <= 1'b0;
      bvalid      <= 1'b0;
      bid         <= '0;
      bresp       <= RESP_OKAY;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= BURST_FIXED;
      beat_cnt    <= '0;
      err_early_q <= 1'b0;
      err_late_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (awvalid && awready) begin
            id_q        <= awid;
            addr_q      <= awaddr;
            len_q       <= awlen;
            size_q      <= awsize;
            burst_q     <= burst_t'(awburst);
            beat_cnt    <= '0;
            err_early_q <= aw_err;
            err_late_q  <= 1'b0;
            awready     <= 1'b0;
            wready      <= 1'b1;
            state       <= ST_DATA;
          end else begin
            awready <= 1'b1;
          end
        end
        ST_DATA: begin
          if (w_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            addr_q   <= next_addr;
            if (wlast_bad) err_late_q <= 1'b1;
            if (last_beat) begin
              wready <= 1'b0;
              bvalid <= 1'b1;
              bid    <= id_q;
              bresp  <= (err_early_q || err_late_q || wlast_bad) ? RESP_SLVERR
                                                                  : RESP_OKAY;
              state  <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (bvalid && bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slave_wr_ctrl.sv
module tb_axi_slave_wr_ctrl;

  logic        aclk;
  logic        aresetn;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  axi_slave_wr_ctrl #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } b_t;

  wr_t wq[$];
  b_t  bq[$];
  wr_t mon_w;
  b_t  mon_b;
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Reference model: beat address from the burst rules with plain arithmetic.
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                            input int size, input int burst, input int i);
    longint bytes, win, base, off;
    bytes = longint'(1) << size;
    case (burst)
      1: return 32'((longint'(start) + i * bytes) % (longint'(1) << 32));
      2: begin
        win  = (len + 1) * bytes;
        base = longint'(start) - (longint'(start) % win);
        off  = (longint'(start) - base + i * bytes) % win;
        return 32'(base + off);
      end
      default: return start;
    endcase
  endfunction

  function automatic bit exp_err_early(input int burst, input int size, input int len);
    return (burst == 3) || (size > 2) ||
           ((burst == 2) && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  // Monitor: every memory write and every B handshake is matched to the scoreboard.
  always @(negedge aclk) begin
    if (aresetn === 1'b1) begin
      if (mem_we === 1'b1) begin
        if (wq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: addr 0x%0h with no expected beat", mem_addr);
        end else begin
          mon_w = wq.pop_front();
          check("mem_addr", mem_addr, mon_w.addr);
          check("mem_wdata", mem_wdata, mon_w.data);
          check("mem_wstrb", mem_wstrb, mon_w.strb);
        end
      end
      if (bvalid === 1'b1 && bready === 1'b1) begin
        if (bq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_b: bid 0x%0h bresp 0x%0h with no expected response", bid, bresp);
        end else begin
          mon_b = bq.pop_front();
          check("bid", bid, mon_b.id);
          check("bresp", bresp, mon_b.resp);
        end
      end
    end
  end

  task automatic do_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input int size, input int burst, input int early_last,
                          input bit drop_last, input int bdelay, input bit pre_w,
                          input bit gaps);
    bit          ee;
    bit          el;
    int          t;
    logic [1:0]  eresp;
    logic [31:0] d;
    logic [3:0]  s;
    ee = exp_err_early(burst, size, len);
    el = 1'b0;
    @(posedge aclk); #1;
    awid    = id;
    awaddr  = addr;
    awlen   = 8'(len);
    awsize  = 3'(size);
    awburst = 2'(burst);
    awvalid = 1'b1;
    d = $urandom;
    s = 4'($urandom_range(0, 15));
    if (pre_w) begin
      wdata  = d;
      wstrb  = s;
      wlast  = (len == 0) ? !drop_last : (early_last == 0);
      wvalid = 1'b1;
    end
    t = 0;
    @(negedge aclk);
    while (awready !== 1'b1 && t < 50) begin
      t++;
      @(negedge aclk);
    end
    if (t >= 50) timeout("aw_handshake");
    if (pre_w) check("wready_with_aw", wready, 1'b0);
    @(posedge aclk); #1;
    awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (!(pre_w && i == 0)) begin
        if (gaps && $urandom_range(0, 3) == 0) begin
          wvalid = 1'b0;
          @(posedge aclk); #1;
        end
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        wdata  = d;
        wstrb  = s;
        wlast  = (i == len) ? !drop_last : (i == early_last);
        wvalid = 1'b1;
      end
      if (wlast != (i == len)) el = 1'b1;
      if (!ee) wq.push_back('{addr: beat_addr(addr, len, size, burst, i), data: d, strb: s});
      t = 0;
      @(negedge aclk);
      while (wready !== 1'b1 && t < 50) begin
        t++;
        @(negedge aclk);
      end
      if (t >= 50) timeout("w_handshake");
      @(posedge aclk); #1;
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    eresp  = (ee || el) ? 2'b10 : 2'b00;
    bq.push_back('{id: id, resp: eresp});
    if (bdelay > 0) begin
      bready = 1'b0;
      t = 0;
      @(negedge aclk);
      while (bvalid !== 1'b1 && t < 50) begin
        t++;
        @(negedge aclk);
      end
      if (t >= 50) timeout("bvalid_wait");
      for (int k = 0; k < bdelay; k++) begin
        check("bvalid_hold", bvalid, 1'b1);
        check("bid_hold", bid, id);
        check("bresp_hold", bresp, eresp);
        check("awready_in_resp", awready, 1'b0);
        @(posedge aclk); #1;
        if (k != bdelay - 1) @(negedge aclk);
      end
    end
    bready = 1'b1;
    t = 0;
    @(negedge aclk);
    while (bvalid !== 1'b1 && t < 50) begin
      t++;
      @(negedge aclk);
    end
    if (t >= 50) timeout("b_handshake");
    @(posedge aclk); #1;
    bready = 1'b0;
    @(negedge aclk);
    check("awready_after_b", awready, 1'b1);
  endtask

  task automatic reset_mid_burst();
    int t;
    @(posedge aclk); #1;
    awid = 4'hC; awaddr = 32'h800; awlen = 8'd3; awsize = 3'd2; awburst = 2'b01;
    awvalid = 1'b1;
    t = 0;
    @(negedge aclk);
    while (awready !== 1'b1 && t < 50) begin
      t++;
      @(negedge aclk);
    end
    if (t >= 50) timeout("rst_aw_handshake");
    @(posedge aclk); #1;
    awvalid = 1'b0;
    wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
    wq.push_back('{addr: 32'h800, data: 32'hDEAD_BEEF, strb: 4'hF});
    @(negedge aclk);
    @(posedge aclk); #1;
    wvalid = 1'b0;
    bready = 1'b1;
    #2 aresetn = 1'b0;
    #1;
    check("rst_awready", awready, 1'b0);
    check("rst_wready", wready, 1'b0);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    #1;
    check("awready_before_edge", awready, 1'b0);
    @(posedge aclk); #1;
    check("awready_first_edge", awready, 1'b1);
    repeat (3) @(negedge aclk);
    check("no_b_after_reset", bvalid, 1'b0);
    @(posedge aclk); #1;
    bready = 1'b0;
  endtask

  initial begin
    int burst, size, len, early, bd;
    bit drop, prew;
    logic [31:0] addr;
    aresetn = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    #3;
    check("reset_awready", awready, 1'b0);
    check("reset_wready", wready, 1'b0);
    check("reset_bvalid", bvalid, 1'b0);
    check("reset_bid", bid, 4'h0);
    check("reset_bresp", bresp, 2'b00);
    check("reset_mem_addr", mem_addr, 32'h0);
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;

    do_burst(4'h5, 32'h0000_0100, 3, 2, 1, -1, 0, 0, 0, 0);
    do_burst(4'h1, 32'h0000_0108, 3, 2, 2, -1, 0, 0, 0, 0);
    do_burst(4'h2, 32'h0000_0040, 2, 2, 0, -1, 0, 0, 0, 0);
    do_burst(4'h3, 32'hFFFF_FFFC, 1, 2, 1, -1, 0, 0, 0, 0);
    do_burst(4'h4, 32'h0000_0000, 1, 2, 3, -1, 0, 0, 0, 0);
    do_burst(4'h6, 32'h0000_0200, 2, 2, 2, -1, 0, 0, 0, 0);
    do_burst(4'hB, 32'h0000_0000, 1, 3, 1, -1, 0, 0, 0, 0);
    do_burst(4'h7, 32'h0000_0300, 3, 2, 1, 1, 0, 0, 0, 0);
    do_burst(4'h8, 32'h0000_0400, 1, 2, 1, -1, 1, 0, 0, 0);
    do_burst(4'h9, 32'h0000_0500, 1, 2, 1, -1, 0, 5, 0, 0);
    do_burst(4'hA, 32'h0000_0600, 2, 2, 1, -1, 0, 0, 1, 0);
    do_burst(4'hD, 32'h0000_0710, 0, 1, 1, -1, 0, 1, 0, 0);
    reset_mid_burst();

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2:    burst = 0;
        3, 4, 5, 6: burst = 1;
        7, 8:       burst = 2;
        default:    burst = 3;
      endcase
      size = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      if (burst == 2 && $urandom_range(0, 4) != 0) begin
        case ($urandom_range(0, 3))
          0: len = 1;
          1: len = 3;
          2: len = 7;
          default: len = 15;
        endcase
      end else begin
        len = int'($urandom_range(0, 15));
      end
      addr  = $urandom & ~((32'd1 << size) - 32'd1);
      early = (len > 0 && $urandom_range(0, 9) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      drop  = ($urandom_range(0, 9) == 0);
      bd    = int'($urandom_range(0, 3));
      prew  = ($urandom_range(0, 4) == 0);
      do_burst(4'($urandom_range(0, 15)), addr, len, size, burst, early, drop, bd, prew, 1'b1);
    end

    repeat (3) @(negedge aclk);
    check("writes_drained", wq.size(), 0);
    check("responses_drained", bq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
